ebus_arb: RTL and testbench

//  Arbitrates and sequences the shared EBUS between EBOX-side masters (PI function cycles, APR/CON CONO/CONI/DATAO/DATAI, diag).

---
 rtl/ebus_pkg.sv | 36 +++
 rtl/ebus_arb_rr_pick.sv | 44 ++++
 rtl/ebus_arb.sv | 139 +++++++++++++
 tb/tb_ebus_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_pkg.sv
//------------------------------------------------------------------------------
// ebus_pkg : shared EBUS types (controller select, function codes, arbiter state)
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package ebus_pkg;

   typedef logic [6:0] tEbusCS;

   typedef enum logic [2:0] {
      EF_CONO      = 3'd0,
      EF_CONI      = 3'd1,
      EF_DATAO     = 3'd2,
      EF_DATAI     = 3'd3,
      EF_PI_SERVED = 3'd4,
      EF_PI_ADDR   = 3'd5,
      EF_DIAG      = 3'd6,
      EF_NOP       = 3'd7
   } tEbusFunc;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SETUP   = 2'd1,
      ARB_DEMAND  = 2'd2,
      ARB_RELEASE = 2'd3
   } tArbState;

   // Round-robin successor of the current owner.
   function automatic int rr_next(input int cur, input int n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ebus_arb_rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : first set request at/after pointer, wrapping; one-hot + index out
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         onehot,
   output logic [$clog2(NREQ)-1:0] index,
   output logic                    any
);

   localparam int IW = $clog2(NREQ);

   int            j;
   logic [IW-1:0] jj;

   // Scan from the farthest offset down so the nearest hit wins.
   always_comb begin
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      j      = 0;
      jj     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         jj = IW'(j);
         if (req[jj]) begin
            onehot     = '0;
            onehot[jj] = 1'b1;
            index      = jj;
            any        = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ebus_arb.sv
//------------------------------------------------------------------------------
// ebus_arb : round-robin EBUS owner arbitration and demand/transfer sequencing
//            optional transfer timeout when EBUS_XFER_TIMEOUT_EN is defined
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

module ebus_arb
   import ebus_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int SETUP = 2,
   parameter int TMO   = 1024
) (
   input  logic                 clk,
   input  logic                 CROBAR_N,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0][6:0] reqCS,
   input  logic [NREQ-1:0][2:0] reqFunc,
   input  logic [NREQ-1:0]      reqWrite,
   input  logic                 ebusXfer,
   output logic [6:0]           ebusCS,
   output logic [2:0]           ebusFunc,
   output logic                 ebusDemand,
   output logic                 ebusDrive,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      tmo,
   output logic                 busy
);

   localparam int IW = $clog2(NREQ);
   localparam int SW = $clog2(SETUP + 1);

   if (NREQ < 2 || NREQ > 8 || SETUP < 1 || TMO < 4) begin : g_param_check
      $error("ebus_arb: parameter out of range");
   end

   tArbState        state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner;
   logic [SW-1:0]   setup_cnt;
   tEbusCS          cs_q;
   logic [NREQ-1:0] pick_oh;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            tmo_hit;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .index  (pick_idx),
      .any    (pick_any)
   );

`ifdef EBUS_XFER_TIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);

   logic [TW-1:0] tmo_cnt;

   // Zeroed throughout SETUP so the first DEMAND cycle sees 0; saturates at TMO.
   always_ff @(posedge clk) begin
      if (!CROBAR_N) begin
         tmo_cnt <= '0;
      end else if (state == ARB_SETUP) begin
         tmo_cnt <= '0;
      end else if ((state == ARB_DEMAND || state == ARB_RELEASE) && tmo_cnt != TW'(TMO)) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tmo_hit = (tmo_cnt >= TW'(TMO - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!CROBAR_N) begin
         state     <= ARB_IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         setup_cnt <= '0;
         cs_q      <= '0;
         ebusFunc  <= '0;
         ebusDrive <= 1'b0;
         grant     <= '0;
         ack       <= '0;
         tmo       <= '0;
      end else begin
         ack <= '0;
         tmo <= '0;
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  state     <= ARB_SETUP;
                  owner     <= pick_idx;
                  grant     <= pick_oh;
                  cs_q      <= reqCS[pick_idx];
                  ebusFunc  <= reqFunc[pick_idx];
                  ebusDrive <= reqWrite[pick_idx];
                  setup_cnt <= '0;
               end
            end
            ARB_SETUP: begin
               if (setup_cnt == SW'(SETUP - 1)) state <= ARB_DEMAND;
               else setup_cnt <= setup_cnt + 1'b1;
            end
            ARB_DEMAND: begin
               if (ebusXfer) begin
                  ack   <= grant;
                  state <= ARB_RELEASE;
               end else if (tmo_hit) begin
                  tmo   <= grant;
                  state <= ARB_RELEASE;
               end
            end
            ARB_RELEASE: begin
               if (!ebusXfer || tmo_hit) begin
                  state     <= ARB_IDLE;
                  grant     <= '0;
                  ebusDrive <= 1'b0;
                  cs_q      <= '0;
                  ebusFunc  <= '0;
                  rr_ptr    <= IW'(rr_next(int'(owner), NREQ));
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign ebusCS     = cs_q;
   assign ebusDemand = (state == ARB_DEMAND);
   assign busy       = (state != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ebus_arb.sv
//------------------------------------------------------------------------------
// tb_ebus_arb : directed scenarios plus randomized traffic against a
//               transaction-level reference of the EBUS arbiter
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ebus_arb;

   localparam int NREQ  = 4;
   localparam int SETUP = 2;
   localparam int TMO   = 16;

   logic                 clk = 1'b0;
   logic                 CROBAR_N;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0][6:0] reqCS;
   logic [NREQ-1:0][2:0] reqFunc;
   logic [NREQ-1:0]      reqWrite;
   logic                 ebusXfer;
   logic [6:0]           ebusCS;
   logic [2:0]           ebusFunc;
   logic                 ebusDemand;
   logic                 ebusDrive;
   logic [NREQ-1:0]      grant;
   logic [NREQ-1:0]      ack;
   logic [NREQ-1:0]      tmo;
   logic                 busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ebus_arb #(.NREQ(NREQ), .SETUP(SETUP), .TMO(TMO)) dut (
      .clk        (clk),
      .CROBAR_N   (CROBAR_N),
      .req        (req),
      .reqCS      (reqCS),
      .reqFunc    (reqFunc),
      .reqWrite   (reqWrite),
      .ebusXfer   (ebusXfer),
      .ebusCS     (ebusCS),
      .ebusFunc   (ebusFunc),
      .ebusDemand (ebusDemand),
      .ebusDrive  (ebusDrive),
      .grant      (grant),
      .ack        (ack),
      .tmo        (tmo),
      .busy       (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      CROBAR_N = 1'b0;
      req      = '0;
      ebusXfer = 1'b0;
      tick;
      tick;
      CROBAR_N = 1'b1;
   endtask

   task automatic wait_demand(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ebusDemand) begin ok = 1'b1; break; end
         tick;
      end
   endtask

   task automatic run_until_idle(output bit ok);
      ok  = 1'b0;
      req = '0;
      for (int i = 0; i < 50; i++) begin
         if (!busy) begin ok = 1'b1; break; end
         ebusXfer = ebusDemand;
         tick;
      end
      ebusXfer = 1'b0;
   endtask

   task automatic test_reset;
      bit ok;
      CROBAR_N = 1'b0;
      req      = 4'b1111;
      ebusXfer = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         reqCS[i] = 7'($urandom); reqFunc[i] = 3'($urandom); reqWrite[i] = 1'b1;
      end
      for (int c = 0; c < 3; c++) begin
         tick;
         checks++;
         if ({grant, ack, tmo, ebusCS, ebusFunc, ebusDemand, ebusDrive, busy} !== 25'd0)
            begin errors++; $display("FAIL reset_outputs: got %h want 0", {grant, ack, tmo, ebusCS, ebusFunc, ebusDemand, ebusDrive, busy}); end
      end
      CROBAR_N = 1'b1;
      tick;
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1)
         begin errors++; $display("FAIL reset_first_grant: got grant=%b busy=%b want 0001/1", grant, busy); end
      run_until_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_drain: bus still busy, want idle"); end
   endtask

   task automatic test_single;
      bit ok;
      int n;
      do_reset;
      reqCS[2] = 7'o14; reqFunc[2] = 3'd1; reqWrite[2] = 1'b1;
      req = 4'b0100;
      tick;
      checks++;
      if (grant !== 4'b0100 || ebusCS !== 7'o14 || ebusFunc !== 3'd1 || ebusDrive !== 1'b1 || ebusDemand !== 1'b0)
         begin errors++; $display("FAIL single_select: got g=%b cs=%o f=%0d drv=%b dem=%b want 0100/14/1/1/0", grant, ebusCS, ebusFunc, ebusDrive, ebusDemand); end
      n = 0;
      while (!ebusDemand && n < 20) begin tick; n++; end
      checks++;
      if (n != SETUP) begin errors++; $display("FAIL single_setup_len: got %0d want %0d", n, SETUP); end
      tick;
      checks++;
      if (ebusDemand !== 1'b1 || ack !== 4'b0000)
         begin errors++; $display("FAIL single_demand_hold: got dem=%b ack=%b want 1/0000", ebusDemand, ack); end
      ebusXfer = 1'b1;
      tick;
      req = '0;
      checks++;
      if (ack !== 4'b0100 || ebusDemand !== 1'b0 || grant !== 4'b0100)
         begin errors++; $display("FAIL single_ack: got ack=%b dem=%b g=%b want 0100/0/0100", ack, ebusDemand, grant); end
      ebusXfer = 1'b0;
      tick;
      checks++;
      if (ack !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000 || ebusDrive !== 1'b0)
         begin errors++; $display("FAIL single_release: got ack=%b busy=%b g=%b drv=%b want 0000/0/0000/0", ack, busy, grant, ebusDrive); end
      run_until_idle(ok);
   endtask

   task automatic test_round_robin;
      logic [NREQ-1:0] order [8];
      int              acks  [NREQ];
      int              n_g, n_a;
      logic [NREQ-1:0] prev_g, exp_g;
      bit              ok;
      do_reset;
      for (int k = 0; k < 8; k++) order[k] = '0;
      for (int i = 0; i < NREQ; i++) acks[i] = 0;
      n_g = 0; n_a = 0; prev_g = '0;
      req = 4'b1111;
      for (int cyc = 0; cyc < 200 && n_a < 8; cyc++) begin
         ebusXfer = ebusDemand;
         tick;
         if (grant != 0 && prev_g == 0 && n_g < 8) begin order[n_g] = grant; n_g++; end
         prev_g = grant;
         for (int i = 0; i < NREQ; i++) if (ack[i]) begin acks[i]++; n_a++; end
      end
      checks++;
      if (n_a != 8) begin errors++; $display("FAIL rr_budget: got %0d acks want 8", n_a); end
      for (int k = 0; k < 8; k++) begin
         exp_g = '0;
         exp_g[k % NREQ] = 1'b1;
         checks++;
         if (order[k] !== exp_g) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", k, order[k], exp_g); end
      end
      for (int i = 0; i < NREQ; i++) begin
         checks++;
         if (acks[i] != 2) begin errors++; $display("FAIL rr_ack_count[%0d]: got %0d want 2", i, acks[i]); end
      end
      run_until_idle(ok);
   endtask

   task automatic test_timeout;
      bit ok;
      int n;
      do_reset;
      reqCS[1] = 7'o21; reqFunc[1] = 3'd3; reqWrite[1] = 1'b0;
      req = 4'b0010;
      tick;
      wait_demand(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL tmo_wait_demand: no DEMAND within bound"); end
`ifdef EBUS_XFER_TIMEOUT_EN
      n = 0;
      while (tmo == 0 && n < 4 * TMO) begin
         tick; n++;
         checks++;
         if (ack !== 4'b0000) begin errors++; $display("FAIL tmo_no_ack: got ack=%b want 0000", ack); end
      end
      req = '0;
      checks++;
      if (n != TMO || tmo !== 4'b0010)
         begin errors++; $display("FAIL tmo_pulse: got %0d cycles tmo=%b want %0d/0010", n, tmo, TMO); end
      tick;
      checks++;
      if (busy !== 1'b0 || tmo !== 4'b0000 || grant !== 4'b0000)
         begin errors++; $display("FAIL tmo_idle_after: got busy=%b tmo=%b g=%b want 0/0000/0000", busy, tmo, grant); end
`else
      n = 0;
      for (int c = 0; c < 3 * TMO; c++) begin
         tick;
         if (ebusDemand !== 1'b1 || tmo !== 4'b0000 || ack !== 4'b0000) n++;
      end
      checks++;
      if (n != 0) begin errors++; $display("FAIL no_tmo_wait: got %0d bad cycles want 0", n); end
      ebusXfer = 1'b1;
      tick;
      req = '0;
      checks++;
      if (ack !== 4'b0010 || tmo !== 4'b0000)
         begin errors++; $display("FAIL no_tmo_ack: got ack=%b tmo=%b want 0010/0000", ack, tmo); end
`endif
      run_until_idle(ok);
   endtask

   task automatic test_latched_fields;
      bit ok;
      do_reset;
      reqCS[3] = 7'o55; reqFunc[3] = 3'd3; reqWrite[3] = 1'b0;
      req = 4'b1000;
      tick;
      wait_demand(ok);
      req = '0; reqCS[3] = 7'o77; reqFunc[3] = 3'd5; reqWrite[3] = 1'b1;
      tick;
      checks++;
      if (!ok || ebusCS !== 7'o55 || ebusFunc !== 3'd3 || ebusDrive !== 1'b0 || ebusDemand !== 1'b1)
         begin errors++; $display("FAIL latch_hold: got cs=%o f=%0d drv=%b dem=%b want 55/3/0/1", ebusCS, ebusFunc, ebusDrive, ebusDemand); end
      ebusXfer = 1'b1;
      tick;
      checks++;
      if (ack !== 4'b1000) begin errors++; $display("FAIL latch_ack: got %b want 1000", ack); end
      run_until_idle(ok);
   endtask

   task automatic test_reset_mid;
      bit ok;
      int n;
      do_reset;
      req = 4'b0001;
      n = 0;
      for (int c = 0; c < 30 && ack == 0; c++) begin ebusXfer = ebusDemand; tick; n++; end
      checks++;
      if (ack !== 4'b0001) begin errors++; $display("FAIL rmid_first_ack: got %b want 0001", ack); end
      run_until_idle(ok);
      req = 4'b0100;
      tick;
      wait_demand(ok);
      CROBAR_N = 1'b0;
      req      = '0;
      tick;
      checks++;
      if (!ok || ebusDemand !== 1'b0 || grant !== 4'b0000 || ack !== 4'b0000 || tmo !== 4'b0000 || busy !== 1'b0)
         begin errors++; $display("FAIL rmid_abort: got dem=%b g=%b ack=%b tmo=%b busy=%b want all 0", ebusDemand, grant, ack, tmo, busy); end
      CROBAR_N = 1'b1;
      req      = 4'b1111;
      tick;
      checks++;
      if (grant !== 4'b0001 || ack !== 4'b0000)
         begin errors++; $display("FAIL rmid_ptr_cleared: got g=%b ack=%b want 0001/0000", grant, ack); end
      run_until_idle(ok);
   endtask

   // Reference: tracks owner, cycles since grant, and whether the transfer completed.
   task automatic test_random;
      bit                   m_owned, m_acked, p_xfer, exp_dem, found, ok;
      int                   m_owner, m_t, m_ptr, rel_t, j;
      logic [6:0]           m_cs;
      logic [2:0]           m_func;
      bit                   m_wr;
      logic [NREQ-1:0]      p_req, p_wr, exp_ack, exp_grant;
      logic [NREQ-1:0][6:0] p_cs;
      logic [NREQ-1:0][2:0] p_func;
      do_reset;
      m_owned = 0; m_acked = 0; m_owner = 0; m_t = 0; m_ptr = 0; rel_t = 0;
      m_cs = '0; m_func = '0; m_wr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         p_req = req; p_cs = reqCS; p_func = reqFunc; p_wr = reqWrite; p_xfer = ebusXfer;
         tick;
         exp_ack = '0;
         if (m_owned && !m_acked && m_t >= SETUP && p_xfer) begin
            m_acked = 1; exp_ack[m_owner] = 1'b1; m_t++;
         end else if (m_owned && m_acked && !p_xfer) begin
            m_owned = 0; m_ptr = (m_owner + 1) % NREQ;
         end else if (!m_owned && p_req != 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
               j = (m_ptr + k) % NREQ;
               if (!found && p_req[j]) begin found = 1; m_owner = j; end
            end
            m_owned = 1; m_acked = 0; m_t = 0;
            m_cs = p_cs[m_owner]; m_func = p_func[m_owner]; m_wr = p_wr[m_owner];
         end else if (m_owned) begin
            m_t++;
         end
         exp_grant = '0;
         if (m_owned) exp_grant[m_owner] = 1'b1;
         exp_dem = m_owned && !m_acked && m_t >= SETUP;
         checks++;
         if (grant !== exp_grant || ack !== exp_ack || tmo !== 4'b0000)
            begin errors++; $display("FAIL rand_vec@%0d: got g=%b ack=%b tmo=%b want %b/%b/0000", cyc, grant, ack, tmo, exp_grant, exp_ack); end
         checks++;
         if (ebusDemand !== exp_dem || busy !== m_owned || ebusDrive !== (m_owned && m_wr))
            begin errors++; $display("FAIL rand_ctl@%0d: got dem=%b busy=%b drv=%b want %b/%b/%b", cyc, ebusDemand, busy, ebusDrive, exp_dem, m_owned, m_owned && m_wr); end
         if (m_owned) begin
            checks++;
            if (ebusCS !== m_cs || ebusFunc !== m_func)
               begin errors++; $display("FAIL rand_fields@%0d: got cs=%o f=%0d want %o/%0d", cyc, ebusCS, ebusFunc, m_cs, m_func); end
         end
         for (int i = 0; i < NREQ; i++) begin
            reqCS[i] = 7'($urandom); reqFunc[i] = 3'($urandom); reqWrite[i] = 1'($urandom);
            if (exp_ack[i]) req[i] = 1'b0;
            else if (!req[i]) req[i] = ($urandom_range(3) == 0);
            else if (m_owned && i == m_owner && m_t >= SETUP && $urandom_range(5) == 0) req[i] = 1'b0;
         end
         if (!m_owned) begin ebusXfer = 1'b0; rel_t = 0; end
         else if (m_acked) begin rel_t++; if (rel_t >= 4 || $urandom_range(1) == 0) ebusXfer = 1'b0; end
         else begin rel_t = 0; ebusXfer = (m_t >= SETUP + 4) ? 1'b1 : ($urandom_range(2) == 0); end
      end
      run_until_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_drain: bus still busy, want idle"); end
   endtask

   initial begin
      CROBAR_N = 1'b0;
      req      = '0;
      reqCS    = '0;
      reqFunc  = '0;
      reqWrite = '0;
      ebusXfer = 1'b0;
      test_reset;
      test_single;
      test_round_robin;
      test_timeout;
      test_latched_fields;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
